scl_edge_filt: RTL
==================

# scl_edge_filt

Parametrised multi-channel successor to the single-line SCL edge detector in the I2C receive path. Each channel synchronises an asynchronous input line, rejects glitches shorter than a programmable number of clocks, and produces a filtered level plus one-cycle rising and falling edge pulses. Sticky per-channel edge flags let slower control logic poll for activity. Channels are typically SCL and SDA, with NCH=2.

## Interface
Parameters:
- NCH, 2: number of independent input lines (≥1).
- SYNC_STAGES, 2: synchroniser depth (≥2).
- FILT_LEN, 4: consecutive cycles a new level must persist before it is accepted (≥1; 1 = no filtering).
- RESET_LEVEL, 1'b1: reset value of every synchroniser flop and filtered level (idle-high bus).

Ports:
- clk  in  1  system clock; all flops on rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- line_in  in  NCH  raw asynchronous input lines.
- filt_bypass  in  1  1 = treat FILT_LEN as 1 on all channels.
- flag_clr  in  NCH  per-channel clear of sticky flags (synchronous, one-cycle).
- line_filt  out  NCH  filtered, synchronised level.
- rising_edge_found  out  NCH  one-cycle pulse, filtered 0→1.
- falling_edge_found  out  NCH  one-cycle pulse, filtered 1→0.
- rise_seen  out  NCH  sticky: a rising edge occurred since the last clear.
- fall_seen  out  NCH  sticky: a falling edge occurred since the last clear.

## Operation
- Reset values:
  - Sync chain = RESET_LEVEL; line_filt = RESET_LEVEL.
  - Filter counter = 0; edge pulses = 0; sticky flags = 0.
  - No edge is ever reported as a consequence of reset release if line_in equals RESET_LEVEL.
- Synchroniser: line_in passes through SYNC_STAGES flops. The last stage is s.
- Filter, per channel, counter cnt of width $clog2(FILT_LEN+1), evaluated each edge:
  - s == line_filt: cnt ← 0.
  - s != line_filt and (cnt == FILT_LEN-1 or filt_bypass): line_filt ← s, cnt ← 0, and the matching edge pulse is asserted the same cycle line_filt changes.
  - Otherwise: cnt ← cnt+1.
- Glitch rejection:
  - A pulse at s shorter than FILT_LEN cycles resets the count on return and produces no edge.
  - The count never wraps. It is bounded by FILT_LEN-1.
- Edge pulses:
  - Registered, exactly one cycle wide.
  - Rising and falling are never both high on one channel.
  - Back-to-back opposite edges are FILT_LEN cycles apart minimum (1 with bypass).
- Sticky flags:
  - Set on the cycle the edge pulse is high; cleared by flag_clr.
  - If clear and set coincide, set wins.
- Bypass toggling mid-count: cnt is cleared on any cycle filt_bypass is 1. Deasserting bypass restarts counting from 0.
- Channels are fully independent. There is no cross-channel interaction.
- Reset asserted mid-operation: all state returns to its reset values immediately (asynchronously). Pulses in flight are dropped.

## Timing
- A line_in change set up before clock edge E1 is captured by stage 1 at E1. s updates at E(SYNC_STAGES).
- line_filt and the edge pulse update at E(SYNC_STAGES+FILT_LEN). This is 6 edges with the defaults and SYNC_STAGES+1 with bypass.
- Sticky flags are visible one edge after the edge pulse.
- flag_clr takes effect at the next edge.
- All outputs are driven directly from flops. There is no combinational path from any input to any output.

## Structure
- Package scl_edge_pkg holds:
  - Default constants: NCH_DEF, SYNC_STAGES_DEF, FILT_LEN_DEF, RESET_LEVEL_DEF.
  - A cnt_width(FILT_LEN) function.
- Sub-module scl_edge_chan: one channel's synchroniser, filter counter, edge register and sticky flags.
- The top level generates NCH instances and concatenates their outputs.

## Test plan
- Reset and idle: hold n_rst=0 with line_in='1, release, run 20 cycles.
  - All outputs stay at reset values (line_filt='1, edges 0, flags 0).
- Clean falling edge, defaults: drop line_in[0] to 0 0.2·T after an edge.
  - falling_edge_found[0] pulses exactly once, 6 edges later.
  - line_filt[0]=0 from that edge; fall_seen[0]=1 one edge later.
  - Channel 1 is unaffected.
- Glitch rejection: 3-cycle low pulse on line_in[1].
  - No edge, line_filt[1] stays 1.
  - Repeat with a 4-cycle pulse: falling edge, then rising edge 4 cycles after.
- Bypass: filt_bypass=1 and a 1-cycle low pulse.
  - Falling then rising pulses on consecutive cycles, each SYNC_STAGES+1 edges after its input change.
- Sticky clear collision: assert flag_clr[0] on the same cycle a rising edge pulses.
  - rise_seen[0]=1 afterwards.
  - A later clear with no edge gives rise_seen[0]=0.
- Mid-count reset: assert n_rst during the 3rd filter cycle of a transition.
  - Outputs return immediately to reset values.
  - After release with line_in still 0, a falling edge is reported 6 edges later.

Source files
------------

// File: rtl/scl_edge_pkg.sv
// scl_edge_pkg: shared defaults and helpers for the multi-channel SCL/SDA edge filter
package scl_edge_pkg;
    localparam int NCH_DEF = 2;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_LEN_DEF = 4;
    localparam logic RESET_LEVEL_DEF = 1'b1;

    function automatic int cnt_width(input int filt_len);
        return $clog2(filt_len + 1);
    endfunction
endpackage

// File: rtl/scl_edge_chan.sv
// scl_edge_chan: one line's synchroniser, glitch filter, registered edge pulses and sticky flags
module scl_edge_chan
    import scl_edge_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF,
    parameter logic RESET_LEVEL = RESET_LEVEL_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic line_i,
    input  logic bypass_i,
    input  logic clr_i,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o,
    output logic rise_seen_o,
    output logic fall_seen_o
);
    localparam int CW = cnt_width(FILT_LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic filt_q, filt_d, rise_q, rise_d, fall_q, fall_d;
    logic rs_q, rs_d, fs_q, fs_d;
    logic s, accept;

    // a new level is accepted once it has persisted FILT_LEN cycles; the count is capped by acceptance
    always_comb begin
        s = sync_q[SYNC_STAGES-1];
        accept = (s != filt_q) && (bypass_i || cnt_q == CNT_MAX);
        sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
        filt_d = accept ? s : filt_q;
        cnt_d = (s == filt_q || accept || bypass_i) ? '0 : cnt_q + CW'(1);
        rise_d = accept & s;
        fall_d = accept & ~s;
        rs_d = rise_q | (rs_q & ~clr_i);
        fs_d = fall_q | (fs_q & ~clr_i);
    end

    // state registers; reset level on the sync chain avoids a spurious edge at reset release
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            filt_q <= RESET_LEVEL;
            cnt_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            rs_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            rs_q <= rs_d;
            fs_q <= fs_d;
        end
    end

    assign filt_o = filt_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign rise_seen_o = rs_q;
    assign fall_seen_o = fs_q;
endmodule

// File: rtl/scl_edge_filt.sv
// scl_edge_filt: NCH independent filtered edge detectors for asynchronous bus lines
module scl_edge_filt
    import scl_edge_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF,
    parameter logic RESET_LEVEL = RESET_LEVEL_DEF
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic [NCH-1:0] line_in,
    input  logic           filt_bypass,
    input  logic [NCH-1:0] flag_clr,
    output logic [NCH-1:0] line_filt,
    output logic [NCH-1:0] rising_edge_found,
    output logic [NCH-1:0] falling_edge_found,
    output logic [NCH-1:0] rise_seen,
    output logic [NCH-1:0] fall_seen
);
    genvar g;
    for (g = 0; g < NCH; g++) begin : g_ch
        scl_edge_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_LEN(FILT_LEN),
            .RESET_LEVEL(RESET_LEVEL)
        ) u_chan (
            .clk(clk),
            .n_rst(n_rst),
            .line_i(line_in[g]),
            .bypass_i(filt_bypass),
            .clr_i(flag_clr[g]),
            .filt_o(line_filt[g]),
            .rise_o(rising_edge_found[g]),
            .fall_o(falling_edge_found[g]),
            .rise_seen_o(rise_seen[g]),
            .fall_seen_o(fall_seen[g])
        );
    end
endmodule
